// File: rtl/sharpen_stream_engine.sv
// ---------------------------------------------------------------------------
// sharpen_stream_engine
// Streaming 3x3 sharpening filter over a raster-order pixel stream.
// Two line buffers hold the two previous rows; together with the incoming
// pixel they supply one new window column per accepted pixel. Output pixel
// j = k - IMG_W - 1 is computed and registered when input k is accepted, so
// after the last input a FLUSH phase emits the remaining IMG_W+1 outputs.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      one-cycle pulse, starts a frame from IDLE or DONE
//   in_valid   / in_ready / in_pix   : input pixel handshake
//   out_valid  / out_ready / out_pix : output pixel handshake
//   out_last   high with the final pixel of the frame
//   busy       high while a frame is in progress (FILL/RUN/FLUSH)
//   halt       frame complete; sticky until start or reset
// ---------------------------------------------------------------------------
module sharpen_stream_engine #(
    parameter int IMG_W       = 800,
    parameter int IMG_H       = 600,
    parameter int PIX_W       = 8,
    parameter int BORDER_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_last,
    output logic             busy,
    output logic             halt
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int SW = PIX_W + 5;
    localparam logic [XW-1:0]        X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0]        Y_LAST = YW'(IMG_H - 1);
    localparam logic signed [SW-1:0] S_MAX  = SW'((2 ** PIX_W) - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t             r_state;
    logic [XW-1:0]      r_in_x;
    logic [YW-1:0]      r_in_y;
    logic [XW-1:0]      r_out_x;
    logic [YW-1:0]      r_out_y;
    logic               r_out_valid;
    logic               r_out_last;
    logic [PIX_W-1:0]   r_out_pix;
    logic               r_halt;
    logic               r_all_loaded;

    // Line buffers: r_lb0 holds row y-2, r_lb1 holds row y-1 (relative to
    // the row of the incoming pixel).
    logic [PIX_W-1:0]   r_lb0 [IMG_W];
    logic [PIX_W-1:0]   r_lb1 [IMG_W];

    // Two stored window columns [col][row]; column 1 is the newest. The
    // third (rightmost) column is the one being formed from the line buffers
    // and the incoming pixel, so the output can be registered on accept.
    logic [PIX_W-1:0]   r_win [2][3];

    logic               w_out_free;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_flush_step;
    logic               w_step;
    logic               w_load;
    logic [PIX_W-1:0]   w_top;
    logic [PIX_W-1:0]   w_mid;
    logic [PIX_W-1:0]   w_centre;
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_s;
    logic               w_border;
    logic [PIX_W-1:0]   w_pix_next;

    function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({{5{1'b0}}, p});
    endfunction

    assign w_out_free   = !r_out_valid || out_ready;
    assign in_ready     = (r_state == S_FILL) || ((r_state == S_RUN) && w_out_free);
    assign w_in_fire    = in_valid && in_ready;
    assign w_out_fire   = r_out_valid && out_ready;
    assign w_flush_step = (r_state == S_FLUSH) && w_out_free && !r_all_loaded;
    assign w_step       = w_in_fire || w_flush_step;
    assign w_load       = (w_in_fire && (r_state == S_RUN)) || w_flush_step;

    assign w_top    = r_lb0[r_in_x];
    assign w_mid    = r_lb1[r_in_x];
    assign w_centre = r_win[1][1];

    // During FLUSH in_pix is not a real pixel, but every FLUSH output is a
    // border pixel, so only the centre is used there.
    always_comb begin
        w_sum = ext(r_win[0][0]) + ext(r_win[0][1]) + ext(r_win[0][2])
              + ext(r_win[1][0]) + ext(r_win[1][2])
              + ext(w_top) + ext(w_mid) + ext(in_pix);
        w_s   = (ext(w_centre) <<< 3) + ext(w_centre) - w_sum;
    end

    assign w_border = (r_out_x == '0) || (r_out_x == X_LAST) ||
                      (r_out_y == '0) || (r_out_y == Y_LAST);

    always_comb begin
        w_pix_next = '0;
        if (w_border) begin
            w_pix_next = (BORDER_MODE == 1) ? '0 : w_centre;
        end else if (w_s[SW-1]) begin
            w_pix_next = '0;
        end else if (w_s > S_MAX) begin
            w_pix_next = '1;
        end else begin
            w_pix_next = w_s[PIX_W-1:0];
        end
    end

    // Control, counters and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_in_x       <= '0;
            r_in_y       <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_pix    <= '0;
            r_halt       <= 1'b0;
            r_all_loaded <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_FILL;
                        r_halt       <= 1'b0;
                        r_in_x       <= '0;
                        r_in_y       <= '0;
                        r_out_x      <= '0;
                        r_out_y      <= '0;
                        r_all_loaded <= 1'b0;
                    end
                end
                S_FILL: begin
                    // Index IMG_W is the first pixel of row 1.
                    if (w_in_fire && (r_in_x == '0) && (r_in_y == YW'(1))) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_in_fire && (r_in_x == X_LAST) && (r_in_y == Y_LAST)) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_out_fire && r_out_last) begin
                        r_state <= S_DONE;
                        r_halt  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Input position keeps advancing through FLUSH so the line
            // buffers keep being read in column order.
            if (w_step) begin
                if (r_in_x == X_LAST) begin
                    r_in_x <= '0;
                    r_in_y <= (r_in_y == Y_LAST) ? '0 : r_in_y + YW'(1);
                end else begin
                    r_in_x <= r_in_x + XW'(1);
                end
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_pix   <= w_pix_next;
                r_out_last  <= (r_out_x == X_LAST) && (r_out_y == Y_LAST);
                if ((r_out_x == X_LAST) && (r_out_y == Y_LAST)) begin
                    r_all_loaded <= 1'b1;
                end
                if (r_out_x == X_LAST) begin
                    r_out_x <= '0;
                    r_out_y <= (r_out_y == Y_LAST) ? '0 : r_out_y + YW'(1);
                end else begin
                    r_out_x <= r_out_x + XW'(1);
                end
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    // Line buffers and window carry no reset: their contents are only
    // consumed after being refilled by the current frame.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_lb0[r_in_x] <= w_mid;
            r_lb1[r_in_x] <= in_pix;
        end
        if (w_step) begin
            for (int r = 0; r < 3; r++) begin
                r_win[0][r] <= r_win[1][r];
            end
            r_win[1][0] <= w_top;
            r_win[1][1] <= w_mid;
            r_win[1][2] <= in_pix;
        end
    end

    assign out_valid = r_out_valid;
    assign out_pix   = r_out_pix;
    assign out_last  = r_out_last;
    assign halt      = r_halt;
    assign busy      = (r_state == S_FILL) || (r_state == S_RUN) || (r_state == S_FLUSH);

endmodule

// File: tb/tb_sharpen_stream_engine.sv
// ---------------------------------------------------------------------------
// Bench for sharpen_stream_engine at 4x3, 8-bit pixels. Two instances share
// the stimulus: one with pass-through borders, one with zeroed borders.
// Expected outputs come from a behavioural model of the filter and are
// queued per frame; a monitor pops and compares on each output handshake.
// ---------------------------------------------------------------------------
module tb_sharpen_stream_engine;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_pix = 8'd0;
    logic       out_ready = 1'b1;

    logic       in_ready, out_valid, out_last, busy, halt;
    logic [7:0] out_pix;
    logic       in_ready1, out_valid1, out_last1, busy1, halt1;
    logic [7:0] out_pix1;

    int n_assert = 0;
    int n_fail   = 0;
    int recv     = 0;
    bit last_pending = 1'b0;
    int img [N];
    int q0 [$];
    int q1 [$];

    always #5 clk = ~clk;

    sharpen_stream_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .BORDER_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_last(out_last), .busy(busy), .halt(halt)
    );

    sharpen_stream_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .BORDER_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready1), .in_pix(in_pix),
        .out_valid(out_valid1), .out_ready(out_ready), .out_pix(out_pix1),
        .out_last(out_last1), .busy(busy1), .halt(halt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference filter: border -> centre or 0, interior -> clamp(9c - neighbours).
    function automatic int model(input int j, input int bm);
        int x = j % W;
        int y = j / W;
        int c = img[j];
        int s;
        if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return (bm != 0) ? 0 : c;
        s = 9 * c;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx != 0 || dy != 0) s -= img[(y + dy) * W + x + dx];
            end
        end
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    // Output monitor: sample at negedge, a handshake completes on the next posedge.
    always @(negedge clk) begin
        if (last_pending) begin
            chk("halt_after_last", 32'(halt), 32'd1);
            last_pending = 1'b0;
        end
        if (reset && out_valid && out_ready) begin
            n_assert++;
            assert (q0.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_out observed=%0d expected=no_output", out_pix);
            end
            if (q0.size() > 0) chk($sformatf("dut0_out%0d", recv), 32'({out_last, out_pix}), 32'(q0.pop_front()));
            chk("dut1_valid", 32'(out_valid1), 32'd1);
            if (q1.size() > 0) chk($sformatf("dut1_out%0d", recv), 32'({out_last1, out_pix1}), 32'(q1.pop_front()));
            if (out_last) begin
                chk("halt_before_last", 32'(halt), 32'd0);
                last_pending = 1'b1;
            end
            recv++;
        end
    end

    // Queue the frame's expectations, start it, and feed n_in pixels with
    // up to gap_max idle cycles before each; start is re-pulsed at pixel start_at.
    task automatic drive_frame(input int gap_max, input int start_at, input int n_in);
        for (int j = 0; j < N; j++) begin
            q0.push_back(model(j, 0) | ((j == N - 1) ? 256 : 0));
            q1.push_back(model(j, 1) | ((j == N - 1) ? 256 : 0));
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_halt_clear", 32'(halt), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        for (int k = 0; k < n_in; k++) begin
            int gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            int budget = 0;
            bit accepted = 1'b0;
            in_valid = 1'b0;
            repeat (gaps) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_pix   = 8'(img[k]);
            start    = (k == start_at);
            while (!accepted && budget < 200) begin
                bit acc;
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                budget++;
                if (acc) accepted = 1'b1;
            end
            if (!accepted) begin
                n_assert++;
                n_fail++;
                $error("FAIL input_accept_timeout observed=none expected=pixel%0d", k);
                in_valid = 1'b0;
                return;
            end
            if (k == W)     chk("latency_before", 32'(out_valid), 32'd0);
            if (k == W + 1) chk("latency_first", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        if (n_in == N) begin
            int b = 0;
            while (halt !== 1'b1 && b < 200) begin @(negedge clk); b++; end
            chk("frame_halt", 32'(halt), 32'd1);
            chk("frame_halt_bm1", 32'(halt1), 32'd1);
            chk("frame_busy_done", 32'(busy), 32'd0);
            chk("frame_drained", 32'(q0.size()), 32'd0);
        end
    endtask

    // Hold off the output for five cycles once three outputs have gone by.
    task automatic stall_out();
        int base = recv;
        int b = 0;
        logic [7:0] hold;
        while (recv < base + 3 && b < 500) begin @(posedge clk); b++; end
        #1 out_ready = 1'b0;
        @(negedge clk);
        hold = out_pix;
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_pix", 32'(out_pix), 32'(hold));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_pix", 32'(out_pix), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Flat image.
        for (int i = 0; i < N; i++) img[i] = 100;
        drive_frame(0, -1, N);

        // Single bright interior pixel.
        for (int i = 0; i < N; i++) img[i] = 0;
        img[5] = 10;
        drive_frame(0, -1, N);

        // Upper clamp.
        for (int i = 0; i < N; i++) img[i] = 0;
        img[5] = 255;
        drive_frame(0, -1, N);

        // Lower clamp.
        for (int i = 0; i < N; i++) img[i] = 255;
        img[5] = 0;
        drive_frame(0, -1, N);

        // Random image with output backpressure.
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255, 0));
        fork
            drive_frame(0, -1, N);
            stall_out();
        join

        // Random image with input bubbles and a start pulse during RUN.
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255, 0));
        drive_frame(3, 8, N);

        // Reset after seven inputs abandons the frame.
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255, 0));
        drive_frame(0, -1, 7);
        reset = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_last", 32'(out_last), 32'd0);
        chk("midrst_out_pix", 32'(out_pix), 32'd0);
        chk("midrst_out_pix_bm1", 32'(out_pix1), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_halt", 32'(halt), 32'd0);
        chk("midrst_in_ready", 32'(in_ready1), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_quiet", 32'(out_valid), 32'd0);
            chk("postrst_idle", 32'(busy1), 32'd0);
        end

        // Full frame after the abandoned one.
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255, 0));
        drive_frame(1, -1, N);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sharpen_stream_engine.md
Name: sharpen_stream_engine

Overview:
Parametrised streaming 3x3 sharpening engine. It replaces the fixed 800x600, address-driven fetch/update pipeline with a raster-order pixel stream. Two internal line buffers hold the rows it needs, and valid/ready handshakes apply on input and output. It is configurable in frame size, pixel width and border mode, and signals frame completion on a sticky halt.

Parameters:
IMG_W, 800, pixels per row (>=3)
IMG_H, 600, rows per frame (>=3)
PIX_W, 8, bits per pixel (unsigned)
BORDER_MODE, 0, 0 = border pixels pass through unchanged; 1 = border pixels output as 0

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame when in IDLE or DONE
in_valid  in  1  input pixel valid
in_ready  out  1  engine accepts in_pix this cycle
in_pix  in  PIX_W  input pixel, raster order
out_valid  out  1  out_pix valid
out_ready  in  1  downstream accepts out_pix
out_pix  out  PIX_W  sharpened pixel, raster order
out_last  out  1  high with the final pixel of the frame
busy  out  1  high in FILL/RUN/FLUSH
halt  out  1  frame complete; sticky until start or reset

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0. Input and output counters 0. Line-buffer contents are don't-care. Reset mid-frame abandons the frame; no partial output is emitted afterwards.
- FSM states: IDLE, FILL, RUN, FLUSH, DONE.
  - IDLE/DONE + start -> FILL; clears halt and counters. start is ignored in other states.
  - FILL: in_ready=1. Accepts input indices k=0..IMG_W. After k=IMG_W is accepted -> RUN.
  - RUN: each accepted input k (k>=IMG_W+1) loads output j=k-IMG_W-1 into the output register. After k=IMG_W*IMG_H-1 is accepted -> FLUSH.
  - FLUSH: no input accepted (in_ready=0). Emits the remaining IMG_W+1 outputs, one per output handshake. After the last output handshake -> DONE.
  - DONE: halt=1, busy=0.
- Handshake: transfer occurs when valid&ready. The output register is single-entry.
  - RUN: in_ready = !out_valid | out_ready.
  - Once asserted, out_valid holds, and out_pix/out_last stay stable, until out_ready.
  - in_valid=0 in RUN inserts bubbles; order is preserved and no pixel is lost.
- Latency: out_valid rises the cycle after input k=IMG_W+1 is accepted. Throughput is 1 pixel/cycle with no backpressure.
- Window: output j has centre (x,y), x=j mod IMG_W, y=j div IMG_W. Rows y-1, y, y+1 come from line buffer 0, line buffer 1 and the incoming pixel; a 3x3 register window shifts per accepted pixel (or per flush step).
- Border rule: x=0, x=IMG_W-1, y=0 or y=IMG_H-1.
  - BORDER_MODE 0 -> out_pix = centre.
  - BORDER_MODE 1 -> out_pix = 0.
  - All FLUSH outputs are border pixels.
- Interior arithmetic: s = 9*centre - (sum of 8 neighbours), signed, width PIX_W+5. Clamp to [0, 2^PIX_W-1]: s<0 -> 0; s>max -> max.
- out_last=1 exactly with j=IMG_W*IMG_H-1.
- halt rises the cycle after the out_last handshake.
- start while busy: ignored. in_valid outside FILL/RUN: ignored (in_ready=0).
- Counters: the x/y counters wrap at IMG_W/IMG_H; widths are clog2 of each dimension.

Test Plan:
- IMG_W=4, IMG_H=3, all inputs 100, out_ready=1 -> 12 outputs all 100; first out_valid the cycle after input 5 is accepted; out_last on output 12; halt=1 the following cycle.
- Same size, input (1,1)=10, others 0 -> out(1,1)=90, out(2,1)=0 (clamped from -10), all border outputs 0 except (1,1)'s centre rule unchanged; BORDER_MODE=1 gives identical interior values with all border outputs 0.
- Centre (1,1)=255, neighbours 0, PIX_W=8 -> out(1,1)=255 (2295 clamped); neighbours 255, centre 0 -> 0.
- out_ready=0 for 5 cycles mid-RUN -> out_pix/out_valid stable, in_ready=0, and the full 12-pixel sequence still matches the golden model; random in_valid gaps give the same result.
- Assert reset for 1 cycle after 7 inputs -> all outputs 0, state IDLE, halt=0; then start plus a full frame -> correct 12 outputs and halt.
- start pulsed during RUN -> no effect; start in DONE -> halt clears next cycle and a second frame processes correctly.
